// File: rtl/pr_pwm_sequencer_if.sv
// Control/status and PWM output bundle between the static top and the
// reconfigurable PWM sequencer slot.
interface pr_pwm_sequencer_if;
    logic       i_start;
    logic       i_stop;
    logic       i_loop;
    logic       BZ;
    logic       LED_R;
    logic       LED_G;
    logic       LED_B;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_pat_idx;

    modport master (
        output i_start, i_stop, i_loop,
        input  BZ, LED_R, LED_G, LED_B, o_busy, o_done, o_pat_idx
    );

    modport slave (
        input  i_start, i_stop, i_loop,
        output BZ, LED_R, LED_G, LED_B, o_busy, o_done, o_pat_idx
    );
endinterface

// File: rtl/pr_pwm_sequencer.sv
// Four-pattern PWM sequencer for buzzer + RGB LED: each channel ramps to the
// pattern target, holds, then advances (one-shot or looping), fading out on stop.
module pr_pwm_sequencer #(
    parameter int PRESCALE   = 1000,
    parameter int HOLD_TICKS = 256,
    parameter int STEP       = 1
) (
    input  logic               CLK,
    input  logic               RST,
    pr_pwm_sequencer_if.slave  io_seq
);

    localparam int PW = $clog2(PRESCALE);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [8:0]    STEP9      = 9'(STEP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_FADE = 2'd3;

    // Channel packing everywhere: [0]=BZ, [1]=R, [2]=G, [3]=B.
    function automatic logic [31:0] f_target(input logic [1:0] idx);
        logic [31:0] tgt;
        case (idx)
            2'd0:    tgt = {8'd0,   8'd0,   8'd255, 8'd0};
            2'd1:    tgt = {8'd0,   8'd255, 8'd0,   8'd0};
            2'd2:    tgt = {8'd255, 8'd0,   8'd0,   8'd0};
            2'd3:    tgt = {8'd128, 8'd128, 8'd128, 8'd64};
            default: tgt = 32'd0;
        endcase
        return tgt;
    endfunction

    // 9-bit arithmetic so a large STEP can neither wrap nor overshoot.
    function automatic logic [7:0] f_ramp(input logic [7:0] duty, input logic [7:0] tgt);
        logic [8:0] sum;
        logic [8:0] dif;
        logic [7:0] res;
        sum = {1'b0, duty} + STEP9;
        dif = {1'b0, duty} - {1'b0, tgt};
        if (duty < tgt) begin
            res = (sum > {1'b0, tgt}) ? tgt : sum[7:0];
        end else if (duty > tgt) begin
            res = (dif <= STEP9) ? tgt : (duty - STEP9[7:0]);
        end else begin
            res = duty;
        end
        return res;
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      r_idx;
    logic            r_loop;
    logic [HW-1:0]   r_hold;
    logic [PW-1:0]   r_presc;
    logic [7:0]      r_pwm_cnt;
    logic [3:0][7:0] r_duty;
    logic [3:0]      r_pwm;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_state_nxt;
    logic [1:0]      w_idx_nxt;
    logic            w_loop_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic [PW-1:0]   w_presc_nxt;
    logic [3:0][7:0] w_duty_nxt;
    logic [3:0][7:0] w_ramped;
    logic [31:0]     w_tgt;
    logic            w_tick;
    logic            w_done_nxt;

    // Next-state, duty ramp and prescaler logic.
    always_comb begin
        w_tick      = (r_presc == PRESC_LAST);
        w_tgt       = (r_state == S_FADE) ? 32'd0 : f_target(r_idx);
        for (int ch = 0; ch < 4; ch++) begin
            w_ramped[ch] = f_ramp(r_duty[ch], w_tgt[ch*8 +: 8]);
        end
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_loop_nxt  = r_loop;
        w_hold_nxt  = r_hold;
        w_presc_nxt = w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_duty_nxt = 32'd0;
                if (io_seq.i_start && !io_seq.i_stop) begin
                    w_state_nxt = S_RAMP;
                    w_idx_nxt   = 2'd0;
                    w_loop_nxt  = io_seq.i_loop;
                    w_presc_nxt = {PW{1'b0}};
                    w_hold_nxt  = {HW{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RAMP: begin
                if (io_seq.i_stop) begin
                    w_state_nxt = S_FADE;
                end else if (w_tick) begin
                    w_duty_nxt = w_ramped;
                    if (w_ramped == w_tgt) begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = {HW{1'b0}};
                    end else begin
                        w_state_nxt = S_RAMP;
                    end
                end else begin
                    w_state_nxt = S_RAMP;
                end
            end
            S_HOLD: begin
                if (io_seq.i_stop) begin
                    w_state_nxt = S_FADE;
                end else if (w_tick && (r_hold == HOLD_LAST)) begin
                    w_hold_nxt = {HW{1'b0}};
                    if (r_idx != 2'd3) begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = S_RAMP;
                    end else if (r_loop) begin
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = S_RAMP;
                    end else begin
                        w_state_nxt = S_FADE;
                    end
                end else if (w_tick) begin
                    w_hold_nxt = r_hold + HW'(1);
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_FADE: begin
                if (w_tick) begin
                    w_duty_nxt = w_ramped;
                    if (w_ramped == 32'd0) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = 2'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FADE;
                    end
                end else begin
                    w_state_nxt = S_FADE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_duty_nxt  = 32'd0;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // State, counters and registered PWM/status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_loop    <= 1'b0;
            r_hold    <= {HW{1'b0}};
            r_presc   <= {PW{1'b0}};
            r_pwm_cnt <= 8'd0;
            r_duty    <= 32'd0;
            r_pwm     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_loop    <= w_loop_nxt;
            r_hold    <= w_hold_nxt;
            r_presc   <= w_presc_nxt;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_duty    <= w_duty_nxt;
            for (int ch = 0; ch < 4; ch++) begin
                r_pwm[ch] <= (r_pwm_cnt < r_duty[ch]);
            end
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign io_seq.BZ        = r_pwm[0];
    assign io_seq.LED_R     = r_pwm[1];
    assign io_seq.LED_G     = r_pwm[2];
    assign io_seq.LED_B     = r_pwm[3];
    assign io_seq.o_busy    = r_busy;
    assign io_seq.o_done    = r_done;
    assign io_seq.o_pat_idx = r_idx;

endmodule

// File: tb/tb_pr_pwm_sequencer.sv
// Randomised and directed bench for pr_pwm_sequencer against a behavioural
// model of the pattern/ramp/hold/fade rules.
module tb_pr_pwm_sequencer;

    localparam int PRESCALE   = 4;
    localparam int HOLD_TICKS = 2;
    localparam int STEP       = 64;

    typedef enum int {M_IDLE, M_RAMP, M_HOLD, M_FADE} mmode_t;

    logic clk;
    logic rst;
    pr_pwm_sequencer_if bus ();

    pr_pwm_sequencer #(
        .PRESCALE   (PRESCALE),
        .HOLD_TICKS (HOLD_TICKS),
        .STEP       (STEP)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .io_seq (bus.slave)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int done_cnt  = 0;

    // Pattern table [pattern][channel], channel order BZ,R,G,B.
    int tbl [4][4] = '{'{0, 255, 0, 0}, '{0, 0, 255, 0}, '{0, 0, 0, 255}, '{64, 128, 128, 128}};

    mmode_t m_mode;
    int     m_idx, m_loop, m_hold, m_presc, m_cnt;
    int     m_duty [4];
    bit     m_out  [4];
    bit     m_busy, m_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_ramp(input int d, input int t);
        if (d < t) return (d + STEP > t) ? t : d + STEP;
        if (d > t) return (d - STEP < t) ? t : d - STEP;
        return d;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_idx = 0; m_loop = 0; m_hold = 0; m_presc = 0; m_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            m_duty[c] = 0;
            m_out[c]  = 1'b0;
        end
        m_busy = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void model_step();
        bit tick, settled;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 4; c++) m_out[c] = (m_cnt < m_duty[c]);
        m_cnt   = (m_cnt + 1) % 256;
        tick    = (m_presc == PRESCALE - 1);
        m_presc = tick ? 0 : m_presc + 1;
        m_done  = 1'b0;
        case (m_mode)
            M_IDLE: if (bus.i_start && !bus.i_stop) begin
                m_mode = M_RAMP; m_idx = 0; m_loop = bus.i_loop; m_presc = 0; m_hold = 0;
            end
            M_RAMP: if (bus.i_stop) m_mode = M_FADE;
                else if (tick) begin
                    settled = 1'b1;
                    for (int c = 0; c < 4; c++) begin
                        m_duty[c] = m_ramp(m_duty[c], tbl[m_idx][c]);
                        if (m_duty[c] != tbl[m_idx][c]) settled = 1'b0;
                    end
                    if (settled) begin m_mode = M_HOLD; m_hold = 0; end
                end
            M_HOLD: if (bus.i_stop) m_mode = M_FADE;
                else if (tick) begin
                    m_hold++;
                    if (m_hold == HOLD_TICKS) begin
                        m_hold = 0;
                        if (m_idx < 3) begin m_idx++; m_mode = M_RAMP; end
                        else if (m_loop != 0) begin m_idx = 0; m_mode = M_RAMP; end
                        else m_mode = M_FADE;
                    end
                end
            M_FADE: if (tick) begin
                    settled = 1'b1;
                    for (int c = 0; c < 4; c++) begin
                        m_duty[c] = m_ramp(m_duty[c], 0);
                        if (m_duty[c] != 0) settled = 1'b0;
                    end
                    if (settled) begin m_mode = M_IDLE; m_done = 1'b1; m_idx = 0; end
                end
            default: m_mode = M_IDLE;
        endcase
        m_busy = (m_mode != M_IDLE);
    endfunction

    // One clock: advance model at the edge, compare every output 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (bus.o_done === 1'b1) done_cnt++;
        chk($sformatf("outs@%0d", cyc),
            {23'd0, bus.BZ, bus.LED_R, bus.LED_G, bus.LED_B, bus.o_busy, bus.o_done, bus.o_pat_idx},
            {23'd0, m_out[0], m_out[1], m_out[2], m_out[3], m_busy, m_done, 2'(m_idx)});
    endtask

    task automatic pulse(input logic start, input logic stop, input logic lp);
        bus.i_start = start; bus.i_stop = stop; bus.i_loop = lp;
        cycle();
        bus.i_start = 1'b0; bus.i_stop = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        for (int n = 0; n < budget && bus.o_busy === 1'b1; n++) cycle();
    endtask

    initial begin
        int d0, wraps, maxidx, previdx;
        model_reset();
        rst = 1'b1; bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_loop = 1'b0;
        repeat (3) cycle();
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_idx", bus.o_pat_idx, 0);
        chk("rst_pwm", {bus.BZ, bus.LED_R, bus.LED_G, bus.LED_B}, 0);
        rst = 1'b0;
        repeat (5) cycle();

        // One-shot run through all four patterns.
        d0 = done_cnt; maxidx = 0;
        pulse(1'b1, 1'b0, 1'b0);
        chk("busy_latency", bus.o_busy, 1);
        for (int n = 0; n < 1000 && bus.o_busy === 1'b1; n++) begin
            cycle();
            if (int'(bus.o_pat_idx) > maxidx) maxidx = int'(bus.o_pat_idx);
        end
        chk("oneshot_end_busy", bus.o_busy, 0);
        chk("oneshot_done_cnt", done_cnt - d0, 1);
        chk("oneshot_max_idx", maxidx, 3);

        // Loop mode: three wraps with no done, then stop.
        d0 = done_cnt; wraps = 0;
        pulse(1'b1, 1'b0, 1'b1);
        previdx = int'(bus.o_pat_idx);
        for (int n = 0; n < 3000 && wraps < 3; n++) begin
            cycle();
            if (previdx == 3 && bus.o_pat_idx == 2'd0) wraps++;
            previdx = int'(bus.o_pat_idx);
        end
        chk("loop_wraps", wraps, 3);
        chk("loop_no_done", done_cnt - d0, 0);
        chk("loop_still_busy", bus.o_busy, 1);
        pulse(1'b0, 1'b1, 1'b0);
        run_to_idle(1000);
        chk("loop_stop_done", done_cnt - d0, 1);

        // Stop during P1 ramp once G has reached 128.
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 500 && !(m_mode == M_RAMP && m_idx == 1 && m_duty[2] == 128); n++) cycle();
        chk("p1_ramp_idx", bus.o_pat_idx, 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("stop_fade_busy", bus.o_busy, 1);
        chk("stop_fade_idx", bus.o_pat_idx, 1);
        run_to_idle(1000);
        chk("stop_done_cnt", done_cnt - d0, 1);
        chk("stop_end_idx", bus.o_pat_idx, 0);

        // Start+stop together from IDLE does nothing.
        pulse(1'b1, 1'b1, 1'b1);
        chk("startstop_busy", bus.o_busy, 0);
        repeat (3) cycle();
        chk("startstop_busy2", bus.o_busy, 0);

        // Start while in HOLD is ignored, including its loop request.
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 500 && m_mode != M_HOLD; n++) cycle();
        chk("hold_reached_busy", bus.o_busy, 1);
        pulse(1'b1, 1'b0, 1'b1);
        chk("hold_start_idx", bus.o_pat_idx, 2'(m_idx));
        run_to_idle(2000);
        chk("hold_start_oneshot", done_cnt - d0, 1);

        // Reset in the middle of P2 HOLD.
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 1000 && !(m_mode == M_HOLD && m_idx == 2); n++) cycle();
        chk("p2_hold_idx", bus.o_pat_idx, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstmid_outs", {bus.BZ, bus.LED_R, bus.LED_G, bus.LED_B, bus.o_busy, bus.o_pat_idx}, 0);
        chk("rstmid_done", done_cnt - d0, 0);
        repeat (4) cycle();

        // Random control traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.i_start = ($urandom_range(0, 39) == 0);
            bus.i_stop  = ($urandom_range(0, 69) == 0);
            bus.i_loop  = 1'($urandom_range(0, 1));
            rst         = ($urandom_range(0, 599) == 0);
            cycle();
        end
        bus.i_start = 1'b0; bus.i_stop = 1'b0; rst = 1'b0;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
